// File: rtl/chip_74195_model.sv
// Pin-level emulator of a 74195 4-bit parallel-access shift register, sitting in
// the tester socket: synchronizes the tester's pin drives, models the register, injects faults.
module chip_74195_model #(
   parameter int SYNC_STAGES = 2,
   parameter int OUT_DELAY   = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Pin1,
   input  logic       Pin2,
   input  logic       Pin3,
   input  logic       Pin4,
   input  logic       Pin5,
   input  logic       Pin6,
   input  logic       Pin7,
   input  logic       Pin9,
   input  logic       Pin10,
   output logic       Pin15,
   output logic       Pin14,
   output logic       Pin13,
   output logic       Pin12,
   output logic       Pin11,
   input  logic [2:0] Fault_Sel,
   output logic [7:0] Edge_Count
);

   localparam int IDX_CLR_N  = 0;
   localparam int IDX_J      = 1;
   localparam int IDX_K_N    = 2;
   localparam int IDX_A      = 3;
   localparam int IDX_B      = 4;
   localparam int IDX_C      = 5;
   localparam int IDX_D      = 6;
   localparam int IDX_SH_LD  = 7;
   localparam int IDX_CK     = 8;

   localparam logic [2:0] FAULT_QA_SA0    = 3'd1;
   localparam logic [2:0] FAULT_QD_N_LOST = 3'd2;
   localparam logic [2:0] FAULT_JK_SWAP   = 3'd3;
   localparam logic [2:0] FAULT_SHIFT_REV = 3'd4;
   localparam logic [2:0] FAULT_LOAD_NO_D = 3'd5;
   localparam logic [2:0] FAULT_NO_CLEAR  = 3'd6;
   localparam logic [2:0] FAULT_Q_FROZEN  = 3'd7;

   logic [8:0] pin_vec;
   logic [8:0] sync_r [SYNC_STAGES];
   logic [8:0] pin_s;
   logic       ck_prev;
   logic       ck_edge;

   logic [3:0] q;          // q[0] = QA ... q[3] = QD
   logic [3:0] q_next;
   logic [7:0] cnt;
   logic [7:0] cnt_next;
   logic [3:0] q_post;
   logic [3:0] q_del;

   logic       clr_act;
   logic       j_eff;
   logic       k_n_eff;
   logic       jk_base;
   logic       jk_bit;

   // Data and clock share identical chains so they stay cycle-aligned.
   assign pin_vec = {Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
         ck_prev <= 1'b0;
      end else begin
         sync_r[0] <= pin_vec;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
         ck_prev <= sync_r[SYNC_STAGES-1][IDX_CK];
      end
   end

   assign pin_s   = sync_r[SYNC_STAGES-1];
   assign ck_edge = pin_s[IDX_CK] & ~ck_prev;

   always_comb begin
      q_next   = q;
      cnt_next = cnt;
      clr_act  = ~pin_s[IDX_CLR_N] && (Fault_Sel != FAULT_NO_CLEAR);

      // The swap exchanges the J and K functions, so the active-low K pin
      // becomes J's complement and vice versa.
      if (Fault_Sel == FAULT_JK_SWAP) begin
         j_eff   = ~pin_s[IDX_K_N];
         k_n_eff = ~pin_s[IDX_J];
      end else begin
         j_eff   = pin_s[IDX_J];
         k_n_eff = pin_s[IDX_K_N];
      end

      // With the shift reversed, QD is the stage fed by J/K.
      jk_base = (Fault_Sel == FAULT_SHIFT_REV) ? q[3] : q[0];
      case ({j_eff, k_n_eff})
         2'b00:   jk_bit = 1'b0;
         2'b11:   jk_bit = 1'b1;
         2'b01:   jk_bit = jk_base;
         default: jk_bit = ~jk_base;
      endcase

      if (clr_act) begin
         if (Fault_Sel != FAULT_Q_FROZEN) q_next = 4'b0000;
      end else if (ck_edge) begin
         cnt_next = cnt + 8'd1;
         if (Fault_Sel != FAULT_Q_FROZEN) begin
            if (!pin_s[IDX_SH_LD]) begin
               q_next = {pin_s[IDX_D], pin_s[IDX_C], pin_s[IDX_B], pin_s[IDX_A]};
               if (Fault_Sel == FAULT_LOAD_NO_D) q_next[3] = q[3];
            end else if (Fault_Sel == FAULT_SHIFT_REV) begin
               q_next = {jk_bit, q[3:1]};
            end else begin
               q_next = {q[2:0], jk_bit};
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         q   <= 4'b0000;
         cnt <= 8'd0;
      end else begin
         q   <= q_next;
         cnt <= cnt_next;
      end
   end

   assign Edge_Count = cnt;
   assign q_post     = (Fault_Sel == FAULT_QA_SA0) ? {q[3:1], 1'b0} : q;

   generate
      if (OUT_DELAY == 0) begin : g_no_pipe
         assign q_del = q_post;
      end else begin : g_pipe
         logic [3:0] pipe_r [OUT_DELAY];
         always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
               for (int i = 0; i < OUT_DELAY; i++) pipe_r[i] <= 4'b0000;
            end else begin
               pipe_r[0] <= q_post;
               for (int i = 1; i < OUT_DELAY; i++) pipe_r[i] <= pipe_r[i-1];
            end
         end
         assign q_del = pipe_r[OUT_DELAY-1];
      end
   endgenerate

   assign Pin15 = q_del[0];
   assign Pin14 = q_del[1];
   assign Pin13 = q_del[2];
   assign Pin12 = q_del[3];
   assign Pin11 = (Fault_Sel == FAULT_QD_N_LOST) ? q_del[3] : ~q_del[3];

endmodule

// File: tb/tb_chip_74195_model.sv
// Directed bench for chip_74195_model: load, J/K shift, clear priority,
// fault injection, edge-count wrap and asynchronous reset.
module tb_chip_74195_model;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Pin1 = 1'b0, Pin2 = 1'b0, Pin3 = 1'b0, Pin4 = 1'b0, Pin5 = 1'b0;
   logic       Pin6 = 1'b0, Pin7 = 1'b0, Pin9 = 1'b0, Pin10 = 1'b0;
   logic       Pin15, Pin14, Pin13, Pin12, Pin11;
   logic [2:0] Fault_Sel = 3'd0;
   logic [7:0] Edge_Count;

   int n_checks = 0;
   int n_pass   = 0;

   chip_74195_model #(.SYNC_STAGES(2), .OUT_DELAY(1)) dut (
      .Clk(Clk), .Reset(Reset),
      .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5),
      .Pin6(Pin6), .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10),
      .Pin15(Pin15), .Pin14(Pin14), .Pin13(Pin13), .Pin12(Pin12), .Pin11(Pin11),
      .Fault_Sel(Fault_Sel), .Edge_Count(Edge_Count)
   );

   always #5 Clk = ~Clk;

   // Observed register as {QD, QC, QB, QA}
   function automatic logic [7:0] q_obs();
      return {4'b0000, Pin12, Pin13, Pin14, Pin15};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic set_data(input logic a, input logic b, input logic c, input logic d);
      Pin4 = a; Pin5 = b; Pin6 = c; Pin7 = d;
   endtask

   task automatic pulse();
      @(posedge Clk); #1 Pin10 = 1'b1;
      wait_clk(3);
      Pin10 = 1'b0;
      wait_clk(5);
   endtask

   task automatic all_pins_low();
      {Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10} = '0;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      wait_clk(2);
      all_pins_low();
      Reset = 1'b1;
      wait_clk(4);
   endtask

   initial begin
      // Reset state, during and after reset
      #3;
      check("rst_q", q_obs(), 8'h00);
      check("rst_qd_n", {7'b0, Pin11}, 8'h01);
      check("rst_cnt", Edge_Count, 8'h00);
      wait_clk(3);
      Reset = 1'b1;
      wait_clk(4);
      check("rel_q", q_obs(), 8'h00);
      check("rel_qd_n", {7'b0, Pin11}, 8'h01);
      check("rel_cnt", Edge_Count, 8'h00);

      // Parallel load A..D = 1,0,1,1 with explicit latency check
      Pin1 = 1'b1; Pin9 = 1'b0;
      set_data(1'b1, 1'b0, 1'b1, 1'b1);
      wait_clk(4);
      @(posedge Clk); #1 Pin10 = 1'b1;
      wait_clk(3);
      check("load_lat_early", q_obs(), 8'h00);
      wait_clk(1);
      check("load_q", q_obs(), 8'h0D);
      check("load_qd_n", {7'b0, Pin11}, 8'h00);
      check("load_cnt", Edge_Count, 8'h01);
      Pin10 = 1'b0;
      wait_clk(5);

      // Shift with J=1, K_n=0 (QA toggles)
      Pin9 = 1'b1; Pin2 = 1'b1; Pin3 = 1'b0;
      pulse();
      check("shift1_q", q_obs(), 8'h0A);
      pulse();
      check("shift2_q", q_obs(), 8'h05);
      check("shift2_qd_n", {7'b0, Pin11}, 8'h01);
      pulse();
      check("shift3_q", q_obs(), 8'h0A);
      check("shift3_cnt", Edge_Count, 8'h04);

      // Clear together with a clock rise: clear wins, edge not counted
      @(posedge Clk); #1 Pin1 = 1'b0; Pin10 = 1'b1;
      wait_clk(6);
      check("clr_edge_q", q_obs(), 8'h00);
      check("clr_edge_cnt", Edge_Count, 8'h04);
      Pin10 = 1'b0;
      wait_clk(3);
      Pin1 = 1'b1;
      wait_clk(4);

      // Reload 0011, then clear+edge with clear ignored (load data equals Q)
      Pin9 = 1'b0;
      set_data(1'b1, 1'b1, 1'b0, 1'b0);
      pulse();
      check("reload_q", q_obs(), 8'h03);
      check("reload_cnt", Edge_Count, 8'h05);
      Fault_Sel = 3'd6;
      @(posedge Clk); #1 Pin1 = 1'b0; Pin10 = 1'b1;
      wait_clk(6);
      check("f6_noclr_q", q_obs(), 8'h03);
      Pin10 = 1'b0;
      wait_clk(3);
      Pin1 = 1'b1;
      wait_clk(4);
      Fault_Sel = 3'd0;

      // J/K swap: J=1, K_n=1 behaves as J=0, K_n=0
      do_reset();
      Pin1 = 1'b1; Pin9 = 1'b1; Pin2 = 1'b1; Pin3 = 1'b1;
      Fault_Sel = 3'd3;
      pulse();
      check("f3_swap_q", q_obs(), 8'h00);
      check("f3_cnt", Edge_Count, 8'h01);

      // Load 1001, then reversed shift with J=0, K_n=0
      Fault_Sel = 3'd0;
      Pin9 = 1'b0;
      set_data(1'b1, 1'b0, 1'b0, 1'b1);
      pulse();
      check("load2_q", q_obs(), 8'h09);
      Fault_Sel = 3'd4;
      Pin9 = 1'b1; Pin2 = 1'b0; Pin3 = 1'b0;
      pulse();
      check("f4_rev_q", q_obs(), 8'h04);
      check("f4_cnt", Edge_Count, 8'h03);

      // Load with D ignored: QD keeps 0
      Fault_Sel = 3'd5;
      Pin9 = 1'b0;
      set_data(1'b1, 1'b1, 1'b1, 1'b1);
      pulse();
      check("f5_load_q", q_obs(), 8'h07);

      // Output-only faults
      Fault_Sel = 3'd1;
      wait_clk(3);
      check("f1_qa_sa0", q_obs(), 8'h06);
      check("f1_qd_n", {7'b0, Pin11}, 8'h01);
      Fault_Sel = 3'd2;
      wait_clk(3);
      check("f2_q", q_obs(), 8'h07);
      check("f2_qd_n_lost", {7'b0, Pin11}, 8'h00);

      // Frozen Q: 256 shift pulses, count wraps back to its start value
      Fault_Sel = 3'd7;
      Pin9 = 1'b1; Pin2 = 1'b1; Pin3 = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         pulse();
         if (i % 64 == 0) check($sformatf("f7_q_%0d", i), q_obs(), 8'h07);
         if (i == 252) check("f7_cnt_wrap0", Edge_Count, 8'h00);
      end
      check("f7_cnt_end", Edge_Count, 8'h04);

      // Reset mid-shift: outputs return immediately, pipe contents dropped
      Fault_Sel = 3'd0;
      @(posedge Clk); #1 Pin10 = 1'b1;
      wait_clk(3);
      #2 Reset = 1'b0;
      #1;
      check("midrst_q", q_obs(), 8'h00);
      check("midrst_qd_n", {7'b0, Pin11}, 8'h01);
      check("midrst_cnt", Edge_Count, 8'h00);
      all_pins_low();
      wait_clk(2);
      Reset = 1'b1;
      wait_clk(6);
      check("postrst_q", q_obs(), 8'h00);
      check("postrst_cnt", Edge_Count, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
